// File: rtl/memory_mc.sv
// Multi-channel shared memory: round-robin arbitration, byte-strobed writes,
// RD_LAT-cycle read responses and out-of-range error pulses per channel.
module memory_mc #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic [NUM_CH-1:0]            ch_valid,
  output logic [NUM_CH-1:0]            ch_ready,
  input  logic [NUM_CH-1:0]            ch_wr_rd,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*WIDTH-1:0]      ch_wdata,
  input  logic [NUM_CH*WIDTH/8-1:0]    ch_wstrb,
  output logic [NUM_CH*WIDTH-1:0]      ch_rdata,
  output logic [NUM_CH-1:0]            ch_rvalid,
  output logic [NUM_CH-1:0]            ch_err
);

  localparam int unsigned NumBytes = WIDTH / 8;
  localparam int unsigned ChW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ChW-1:0] ptr_q, ptr_d;
  logic [ChW-1:0] gnt_idx;
  logic           acc;

  // Search from the pointer upward with wrap; gating with res keeps ready low in reset.
  always_comb begin
    acc     = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!acc && ch_valid[ChW'((32'(ptr_q) + k) % NUM_CH)]) begin
        acc     = 1'b1;
        gnt_idx = ChW'((32'(ptr_q) + k) % NUM_CH);
      end
    end
    acc = acc & res;
  end

  always_comb begin
    ch_ready = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_ready[i] = acc && (gnt_idx == ChW'(i));
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (acc) begin
      ptr_d = (gnt_idx == ChW'(NUM_CH - 1)) ? '0 : gnt_idx + ChW'(1);
    end
  end

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_wdata;
  logic [NumBytes-1:0]   sel_wstrb;
  logic                  sel_wr;
  logic                  in_range;
  logic [IdxW-1:0]       mem_idx;

  assign sel_addr  = ch_addr[32'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = ch_wdata[32'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_wstrb = ch_wstrb[32'(gnt_idx)*NumBytes +: NumBytes];
  assign sel_wr    = ch_wr_rd[gnt_idx];
  assign in_range  = 32'(sel_addr) < DEPTH;
  assign mem_idx   = sel_addr[IdxW-1:0];

  // Storage is intentionally not reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (acc && sel_wr && in_range) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (sel_wstrb[b]) begin
          mem_q[mem_idx][8*b +: 8] <= sel_wdata[8*b +: 8];
        end
      end
    end
  end

  logic             n_vld, n_err;
  logic [WIDTH-1:0] n_data;

  assign n_vld  = acc & ~sel_wr;
  assign n_err  = ~in_range;
  assign n_data = (n_vld && in_range) ? mem_q[mem_idx] : '0;

  // Response entering the per-channel output registers.
  logic             l_vld, l_err;
  logic [ChW-1:0]   l_ch;
  logic [WIDTH-1:0] l_data;

  if (RD_LAT > 1) begin : g_stage
    logic             s_vld_q, s_vld_d, s_err_q, s_err_d;
    logic [ChW-1:0]   s_ch_q, s_ch_d;
    logic [WIDTH-1:0] s_data_q, s_data_d;

    always_comb begin
      s_vld_d  = n_vld;
      s_err_d  = n_err;
      s_ch_d   = gnt_idx;
      s_data_d = n_data;
    end

    always_ff @(posedge clk or negedge res) begin
      if (!res) begin
        s_vld_q  <= 1'b0;
        s_err_q  <= 1'b0;
        s_ch_q   <= '0;
        s_data_q <= '0;
      end else begin
        s_vld_q  <= s_vld_d;
        s_err_q  <= s_err_d;
        s_ch_q   <= s_ch_d;
        s_data_q <= s_data_d;
      end
    end

    assign l_vld  = s_vld_q;
    assign l_err  = s_err_q;
    assign l_ch   = s_ch_q;
    assign l_data = s_data_q;
  end else begin : g_no_stage
    assign l_vld  = n_vld;
    assign l_err  = n_err;
    assign l_ch   = gnt_idx;
    assign l_data = n_data;
  end

  logic [NUM_CH-1:0]       rvalid_q, rvalid_d, err_q, err_d;
  logic [NUM_CH*WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rvalid_d = '0;
    err_d    = '0;
    rdata_d  = rdata_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (l_vld && (l_ch == ChW'(i))) begin
        rvalid_d[i]                = 1'b1;
        err_d[i]                   = l_err;
        rdata_d[i*WIDTH +: WIDTH]  = l_data;
      end
    end
    // Out-of-range writes report after one cycle regardless of RD_LAT.
    if (acc && sel_wr && !in_range) begin
      err_d[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign ch_rvalid = rvalid_q;
  assign ch_err    = err_q;
  assign ch_rdata  = rdata_q;

endmodule

// File: tb/tb_memory_mc.sv
// Bench for memory_mc (W=32, D=48, AW=6, 2 channels, RD_LAT=2): a transaction-level
// model checks every cycle; directed scenarios add hand-computed literal checks.
module tb_memory_mc;

  localparam int W   = 32;
  localparam int D   = 48;
  localparam int AW  = 6;
  localparam int NC  = 2;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic res = 1'b1;

  logic           v_r  [NC];
  logic           wr_r [NC];
  logic [AW-1:0]  a_r  [NC];
  logic [W-1:0]   d_r  [NC];
  logic [W/8-1:0] s_r  [NC];

  logic [NC-1:0]       ch_valid, ch_ready, ch_wr_rd, ch_rvalid, ch_err;
  logic [NC*AW-1:0]    ch_addr;
  logic [NC*W-1:0]     ch_wdata, ch_rdata;
  logic [NC*W/8-1:0]   ch_wstrb;

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      ch_valid[i]                = v_r[i];
      ch_wr_rd[i]                = wr_r[i];
      ch_addr[i*AW +: AW]        = a_r[i];
      ch_wdata[i*W +: W]         = d_r[i];
      ch_wstrb[i*(W/8) +: (W/8)] = s_r[i];
    end
  end

  memory_mc #(
    .WIDTH     (W),
    .DEPTH     (D),
    .ADDR_WIDTH(AW),
    .NUM_CH    (NC),
    .RD_LAT    (LAT)
  ) dut (
    .clk      (clk),
    .res      (res),
    .ch_valid (ch_valid),
    .ch_ready (ch_ready),
    .ch_wr_rd (ch_wr_rd),
    .ch_addr  (ch_addr),
    .ch_wdata (ch_wdata),
    .ch_wstrb (ch_wstrb),
    .ch_rdata (ch_rdata),
    .ch_rvalid(ch_rvalid),
    .ch_err   (ch_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: storage, rr pointer, responses scheduled by cycle, held read data.
  logic [W-1:0] m_mem [D];
  int           m_ptr = 0;
  int           cyc   = 0;
  logic         pr_v [4][NC];
  logic         pr_e [4][NC];
  logic [W-1:0] pr_d [4][NC];
  logic [W-1:0] m_rd [NC];
  int           glog [$];

  always @(negedge clk) begin
    int            g, slot, a;
    logic [NC-1:0] exp_rdy, exp_rv, exp_er, dg;
    logic [W-1:0]  mask, wd;
    slot = cyc % 4;
    if (!res) begin
      chk("rst_ready", ch_ready, 0);
      chk("rst_rvalid", ch_rvalid, 0);
      chk("rst_err", ch_err, 0);
      chk("rst_rdata", ch_rdata, 0);
      for (int s = 0; s < 4; s++) begin
        for (int c = 0; c < NC; c++) begin
          pr_v[s][c] = 1'b0;
          pr_e[s][c] = 1'b0;
          pr_d[s][c] = '0;
        end
      end
      for (int c = 0; c < NC; c++) m_rd[c] = '0;
      m_ptr = 0;
    end else begin
      g = -1;
      exp_rdy = '0;
      for (int k = 0; k < NC; k++) begin
        if (g < 0 && ch_valid[(m_ptr + k) % NC]) g = (m_ptr + k) % NC;
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      for (int c = 0; c < NC; c++) begin
        exp_rv[c] = pr_v[slot][c];
        exp_er[c] = pr_e[slot][c];
        if (pr_v[slot][c]) m_rd[c] = pr_d[slot][c];
      end
      chk("ready", ch_ready, exp_rdy);
      chk("rvalid", ch_rvalid, exp_rv);
      chk("err", ch_err, exp_er);
      for (int c = 0; c < NC; c++) begin
        chk($sformatf("rdata%0d", c), ch_rdata[c*W +: W], m_rd[c]);
        pr_v[slot][c] = 1'b0;
        pr_e[slot][c] = 1'b0;
      end
      dg = ch_valid & ch_ready;
      if (dg == 2'b01) glog.push_back(0);
      if (dg == 2'b10) glog.push_back(1);
      if (g >= 0) begin
        a = int'(a_r[g]);
        if (wr_r[g]) begin
          if (a < D) begin
            mask = '0;
            for (int b = 0; b < W / 8; b++) if (s_r[g][b]) mask[8*b +: 8] = 8'hFF;
            wd = (m_mem[a] & ~mask) | (d_r[g] & mask);
            m_mem[a] = wd;
          end else begin
            pr_e[(cyc + 1) % 4][g] = 1'b1;
          end
        end else begin
          pr_v[(cyc + LAT) % 4][g] = 1'b1;
          pr_e[(cyc + LAT) % 4][g] = (a >= D);
          pr_d[(cyc + LAT) % 4][g] = (a < D) ? m_mem[a] : '0;
        end
        m_ptr = (g + 1) % NC;
      end
    end
    cyc++;
  end

  // Holds a request until its own ready, then drops valid just after the accept edge.
  task automatic req(input int c, input logic wr, input logic [AW-1:0] a,
                     input logic [W-1:0] d, input logic [W/8-1:0] s);
    logic got;
    got = 1'b0;
    v_r[c] = 1'b1; wr_r[c] = wr; a_r[c] = a; d_r[c] = d; s_r[c] = s;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (ch_ready[c] && res) got = 1'b1;
    end
    chk($sformatf("handshake_ch%0d", c), W'(got), 1);
    if (got) @(posedge clk);
    #1 v_r[c] = 1'b0;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int c = 0; c < NC; c++) begin
      v_r[c] = 1'b0; wr_r[c] = 1'b0; a_r[c] = '0; d_r[c] = '0; s_r[c] = '0;
    end
    #1 res = 1'b0;

    // Reset with both channels requesting (no-op writes); ch0 must win first.
    fork
      req(0, 1'b1, 6'd5, 32'h0, 4'h0);
      req(1, 1'b1, 6'd5, 32'h0, 4'h0);
      begin
        repeat (3) @(posedge clk);
        #1 res = 1'b1;
        @(negedge clk);
        chk("first_grant", ch_ready, 2'b01);
      end
    join

    // Full write then read on ch0.
    sync();
    req(0, 1'b1, 6'd5, 32'hDEADBEEF, 4'hF);
    req(0, 1'b0, 6'd5, 32'h0, 4'h0);
    @(negedge clk);
    chk("rd0_early", ch_rvalid, 2'b00);
    @(negedge clk);
    chk("rd0_rvalid", ch_rvalid, 2'b01);
    chk("rd0_data", ch_rdata[W-1:0], 32'hDEADBEEF);
    chk("model_mem5_full", m_mem[5], 32'hDEADBEEF);

    // Partial write then read on ch1.
    sync();
    req(1, 1'b1, 6'd5, 32'h11223344, 4'h3);
    req(1, 1'b0, 6'd5, 32'h0, 4'h0);
    @(negedge clk);
    chk("rd1_early", ch_rvalid, 2'b00);
    @(negedge clk);
    chk("rd1_rvalid", ch_rvalid, 2'b10);
    chk("rd1_data", ch_rdata[W +: W], 32'hDEAD3344);
    chk("rd0_held", ch_rdata[W-1:0], 32'hDEADBEEF);
    chk("model_mem5_part", m_mem[5], 32'hDEAD3344);

    // Preload, leaving the pointer at ch0.
    sync();
    req(0, 1'b1, 6'd47, 32'h47474747, 4'hF);
    req(0, 1'b1, 6'd1, 32'hA1A1A1A1, 4'hF);
    req(1, 1'b1, 6'd2, 32'hB2B2B2B2, 4'hF);

    // Contention: two reads per channel must alternate.
    glog.delete();
    fork
      begin
        req(0, 1'b0, 6'd1, 32'h0, 4'h0);
        req(0, 1'b0, 6'd1, 32'h0, 4'h0);
      end
      begin
        req(1, 1'b0, 6'd2, 32'h0, 4'h0);
        req(1, 1'b0, 6'd2, 32'h0, 4'h0);
      end
    join
    chk("gnt_count", W'(glog.size()), 4);
    if (glog.size() == 4) begin
      chk("gnt_order", W'((glog[0] << 12) | (glog[1] << 8) | (glog[2] << 4) | glog[3]),
          32'h0101);
    end
    repeat (3) sync();

    // Out-of-range write, out-of-range read, last valid word.
    req(0, 1'b1, 6'd50, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    chk("oor_wr_err", ch_err, 2'b01);
    chk("oor_wr_norv", ch_rvalid, 2'b00);
    sync();
    req(0, 1'b0, 6'd50, 32'h0, 4'h0);
    @(negedge clk);
    chk("oor_rd_early", ch_err, 2'b00);
    @(negedge clk);
    chk("oor_rd_err", ch_err, 2'b01);
    chk("oor_rd_rvalid", ch_rvalid, 2'b01);
    chk("oor_rd_data", ch_rdata[W-1:0], 32'h0);
    sync();
    req(0, 1'b0, 6'd47, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rd47_rvalid", ch_rvalid, 2'b01);
    chk("rd47_err", ch_err, 2'b00);
    chk("rd47_data", ch_rdata[W-1:0], 32'h47474747);

    // Reset while a read is in flight; pointer was at ch1 before reset.
    sync();
    req(0, 1'b0, 6'd5, 32'h0, 4'h0);
    res = 1'b0;
    repeat (2) @(posedge clk);
    #1 res = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("no_rv_after_rst", ch_rvalid, 2'b00);
    end
    sync();
    glog.delete();
    fork
      req(1, 1'b1, 6'd5, 32'h0, 4'h0);
      req(0, 1'b1, 6'd5, 32'h0, 4'h0);
    join
    chk("rst_gnt_count", W'(glog.size()), 2);
    if (glog.size() == 2) chk("rst_ptr_ch0", W'(glog[0]), 0);

    repeat (4) sync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_mc.md
Name: memory_mc

Overview:
- Parametrised multi-channel successor to the single-port valid/ready `memory` block.
- NUM_CH requesters share one WIDTH x DEPTH storage array.
- Each cycle a round-robin arbiter grants at most one request. Writes can use byte strobes.
- Read latency is configurable, with a per-channel read-response valid. Out-of-range accesses raise an error flag.
- The block sits behind the interface_mem-style bus and replaces `memory` where several agents share storage.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 64, number of words; DEPTH <= 2**ADDR_WIDTH.
- ADDR_WIDTH, 6, address width per channel.
- NUM_CH, 2, number of requester channels (1..8).
- RD_LAT, 1, read latency in cycles from accept to rvalid; legal values are 1 and 2.

Ports:
- clk  in  1  clock, rising edge.
- res  in  1  reset, asynchronous, active-low.
- ch_valid  in  NUM_CH  per-channel request valid.
- ch_ready  out  NUM_CH  per-channel grant/accept.
- ch_wr_rd  in  NUM_CH  per-channel op: 1 = write, 0 = read.
- ch_addr  in  NUM_CH*ADDR_WIDTH  channel i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- ch_wdata  in  NUM_CH*WIDTH  write data, sliced per channel.
- ch_wstrb  in  NUM_CH*WIDTH/8  byte enables; bit b covers data byte b.
- ch_rdata  out  NUM_CH*WIDTH  read data, sliced per channel.
- ch_rvalid  out  NUM_CH  one-cycle read-response pulse.
- ch_err  out  NUM_CH  one-cycle error pulse for an out-of-range address.

Behaviour:
- Reset (res low, asynchronous):
  - ch_rvalid, ch_err, ch_rdata and the read pipeline clear to 0.
  - The round-robin pointer resets to channel 0.
  - ch_ready is 0 while res is low.
  - Array contents are not reset; they are undefined until written.
- Arbitration:
  - ch_ready is combinational from ch_valid and the pointer.
  - Exactly one ready is high when any valid is high: the first valid channel searching from the pointer upward, with wrap.
  - No ready is high when no valid is high.
  - Accept = valid & ready at a rising edge.
  - After accepting channel i, the pointer moves to (i+1) mod NUM_CH. With no accept, the pointer holds.
- Requester rule: once valid is high, addr, wr_rd, wdata and wstrb stay stable until accept. The block does not check this.
- Write:
  - The array updates at the accept edge. Byte b is written only where wstrb[b]=1.
  - wstrb = 0 is legal; it is a no-op write and still consumes the grant.
  - Writes produce no rvalid.
- Read, in range:
  - The array is sampled at the accept edge.
  - ch_rvalid[i] pulses for one cycle exactly RD_LAT cycles after the accept edge.
  - ch_rdata slice i holds the data from that cycle until the next rvalid on channel i.
- Read-after-write:
  - A read accepted in the cycle after a write to the same address returns the new data.
  - Writes and reads never coincide, since there is one grant per cycle.
- Out of range (addr >= DEPTH):
  - Write: the array is untouched, and ch_err[i] pulses one cycle after accept.
  - Read: ch_rvalid[i] and ch_err[i] pulse together at RD_LAT, with rdata = 0.
- Back-to-back: one accept per cycle is sustained, so a channel granted in consecutive cycles (others idle) gets consecutive rvalid pulses.
- Reset mid-operation: in-flight reads are discarded, and no rvalid is issued for them after res deasserts.
- Implementation: synchronous-read array plus an RD_LAT-deep pipeline carrying {valid, channel id, err, data}.

Test Plan:
- Config W=32, D=64, AW=6, NUM_CH=2, RD_LAT=2. Hold res=0 for 3 cycles with ch_valid=2'b11 -> ch_ready=0, ch_rvalid=0, ch_err=0, ch_rdata=0. After release, first grant goes to ch0.
- ch0 writes addr 5 = 0xDEADBEEF with wstrb 0xF, then reads addr 5 -> ch_rvalid[0] pulses 2 cycles after the read accept with rdata0 = 0xDEADBEEF; ch_rvalid[1] stays 0.
- ch1 writes addr 5 = 0x11223344 with wstrb 0x3, then reads addr 5 -> rdata1 = 0xDEAD3344.
- Both channels valid for 4 cycles (reads of addr 1 / addr 2) -> grants ch0, ch1, ch0, ch1. rvalid pulses alternate starting 2 cycles after the first accept. Each channel holds valid until its own ready.
- Config D=48: ch0 writes addr 50 = 0xFFFFFFFF -> ch_err[0] pulses 1 cycle later. A read of addr 50 -> rvalid and err pulse together with rdata = 0. A read of addr 47 is unaffected.
- ch0 read of addr 5 is accepted; res is driven low the next cycle and released after 2 cycles -> no ch_rvalid pulse ever appears for that read, and the pointer restarts at ch0.
